// File: rtl/jtag_stream_fifo_pkg.sv
// rtl/jtag_stream_fifo_pkg.sv - shared constants and helpers for jtag_stream_fifo
// Contents: clog2 constant function, err_flags bit indices, drop counter width.
package jtag_stream_fifo_pkg;

    localparam int ERR_TX_OVF  = 0;
    localparam int ERR_RX_UDF  = 1;
    localparam int ERR_RX_DROP = 2;
    localparam int DROP_CNT_W  = 16;

    // Ceiling log2 for elaboration-time sizing of pointers and levels.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jtag_stream_fifo_if.sv
// rtl/jtag_stream_fifo_if.sv - host and link side signal bundle for jtag_stream_fifo
// Parameters: DATA_W word width, DEPTH entries per FIFO (level width AW+1).
// Signals: flush; host wr/wr_data/wr_ready, rd/rd_data/rd_valid, tx_level/rx_level,
//          tx_almost_full/rx_almost_empty; link link_r_ena/link_r_dat/link_r_val,
//          link_t_ena/link_t_dat/link_t_dav.
// Modports: master (host + link environment), slave (the FIFO bridge).
interface jtag_stream_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
);
    import jtag_stream_fifo_pkg::*;

    localparam int AW = clog2(DEPTH);

    logic              flush;
    logic              wr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [AW:0]       tx_level;
    logic [AW:0]       rx_level;
    logic              tx_almost_full;
    logic              rx_almost_empty;
    logic              link_r_ena;
    logic [DATA_W-1:0] link_r_dat;
    logic              link_r_val;
    logic              link_t_ena;
    logic [DATA_W-1:0] link_t_dat;
    logic              link_t_dav;

    modport master (
        output flush, wr, wr_data, rd, link_r_ena, link_t_ena, link_t_dat,
        input  wr_ready, rd_data, rd_valid, tx_level, rx_level,
               tx_almost_full, rx_almost_empty, link_r_dat, link_r_val, link_t_dav
    );

    modport slave (
        input  flush, wr, wr_data, rd, link_r_ena, link_t_ena, link_t_dat,
        output wr_ready, rd_data, rd_valid, tx_level, rx_level,
               tx_almost_full, rx_almost_empty, link_r_dat, link_r_val, link_t_dav
    );

endinterface

// File: rtl/jsf_sync_fifo.sv
// rtl/jsf_sync_fifo.sv - single-clock FIFO with level output and selectable read style
// Parameters: DATA_W, DEPTH (power of two), SHOWAHEAD (1: head visible on dout while
//             not empty; 0: popped word registered onto dout with a 1-cycle valid pulse).
// Ports: clk, rst_n (async low), flush (sync clear, beats push/pop), push/push_data,
//        pop, dout/dout_valid, level (0..DEPTH), full.
module jsf_sync_fifo
    import jtag_stream_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter bit SHOWAHEAD = 1'b0,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [AW:0]       level,
    output logic              full
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    // Full/empty come from the level so a full FIFO is never mistaken for empty.
    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
            else if (!push_ok && pop_ok) level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    if (SHOWAHEAD) begin : g_showahead
        // The read address is the registered rd_ptr, so a word written while empty
        // is visible the cycle level becomes 1. Masked to zero while empty.
        assign dout       = empty ? '0 : mem[rd_ptr_q];
        assign dout_valid = ~empty;
    end else begin : g_registered
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = pop_ok;
            if (flush)       dout_d = '0;
            else if (pop_ok) dout_d = mem[rd_ptr_q];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = valid_q;
    end

endmodule

// File: rtl/jtag_stream_fifo.sv
// rtl/jtag_stream_fifo.sv - host word interface to JTAG link stream bridge, TX and RX FIFOs
// Parameters: DATA_W, DEPTH, AF_THRESH, AE_THRESH, RX_HEADROOM.
// Ports: clk, rst_n (async low), bus (jtag_stream_fifo_if.slave: flush, host and link sides).
// Optional (macro JTAG_STREAM_FIFO_ERR_EN): err_clr in, err_flags[2:0] sticky
//   {rx_drop, rx_underflow_attempt, tx_overflow_attempt}, drop_cnt saturating RX drop count.
module jtag_stream_fifo
    import jtag_stream_fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int AF_THRESH   = DEPTH - 4,
    parameter int AE_THRESH   = 4,
    parameter int RX_HEADROOM = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtag_stream_fifo_if.slave     bus
`ifdef JTAG_STREAM_FIFO_ERR_EN
    ,
    input  logic                  err_clr,
    output logic [2:0]            err_flags,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int          AW      = clog2(DEPTH);
    localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_THRESH);
    localparam logic [AW:0] DAV_LIM = (AW+1)'(DEPTH - RX_HEADROOM);

    logic        tx_full;
    logic        rx_full;
    logic        rx_push;
    logic        rx_pop;
    logic [AW:0] rx_next;
    logic        dav_q, dav_d;

    jsf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SHOWAHEAD(1'b0)) u_tx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.flush),
        .push       (bus.wr),
        .push_data  (bus.wr_data),
        .pop        (bus.link_r_ena),
        .dout       (bus.link_r_dat),
        .dout_valid (bus.link_r_val),
        .level      (bus.tx_level),
        .full       (tx_full)
    );

    jsf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SHOWAHEAD(1'b1)) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.flush),
        .push       (bus.link_t_ena),
        .push_data  (bus.link_t_dat),
        .pop        (bus.rd),
        .dout       (bus.rd_data),
        .dout_valid (bus.rd_valid),
        .level      (bus.rx_level),
        .full       (rx_full)
    );

    assign bus.wr_ready        = ~tx_full;
    assign bus.tx_almost_full  = (bus.tx_level >= AF_LVL);
    assign bus.rx_almost_empty = (bus.rx_level <= AE_LVL);

    // dav is registered from the next-cycle RX level, so it lags the level by
    // nothing but costs the link one cycle to see; RX_HEADROOM covers that lag.
    assign rx_push = bus.link_t_ena & ~rx_full;
    assign rx_pop  = bus.rd & bus.rd_valid;

    always_comb begin
        rx_next = bus.rx_level;
        if (bus.flush)             rx_next = '0;
        else if (rx_push && !rx_pop) rx_next = bus.rx_level + (AW+1)'(1);
        else if (!rx_push && rx_pop) rx_next = bus.rx_level - (AW+1)'(1);
        dav_d = (rx_next <= DAV_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dav_q <= 1'b1;
        else        dav_q <= dav_d;
    end

    assign bus.link_t_dav = dav_q;

`ifdef JTAG_STREAM_FIFO_ERR_EN
    logic [2:0]            err_q, err_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        err_d  = err_q;
        drop_d = drop_q;
        if (bus.flush || err_clr) begin
            err_d  = '0;
            drop_d = '0;
        end else begin
            if (bus.wr && tx_full)         err_d[ERR_TX_OVF] = 1'b1;
            if (bus.rd && !bus.rd_valid)   err_d[ERR_RX_UDF] = 1'b1;
            if (bus.link_t_ena && rx_full) begin
                err_d[ERR_RX_DROP] = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            drop_q <= '0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign err_flags = err_q;
    assign drop_cnt  = drop_q;
`endif

endmodule
